// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the 8-bit pipelined core
// Purpose: default instruction/PC widths and the fetch buffer entry type.
// Ports: none (package).
package core_pkg;

  localparam int IW = 14;
  localparam int AW = 5;

  typedef logic [IW-1:0] inst_t;
  typedef logic [AW-1:0] pc_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO buffering fetched instructions
// Purpose: DEPTH-entry FIFO with synchronous flush; flush beats push/pop.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (also clears storage)
//   flush         - empty the FIFO on this edge
//   push, din     - write din behind the current tail
//   pop           - advance the head
//   dout          - head entry
//   count         - number of valid entries
module fetch_fifo
  import core_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 2,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        dout,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Upstream request gating must never let a response land in a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && count == CW'(DEPTH)));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch front end with PC, memory request and buffer
// Purpose: owns the PC, issues reads to a one-cycle-latency instruction memory,
//          buffers responses and hands them to decode; supports redirects.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   imem_en, imem_addr         - read request to instruction memory
//   imem_data                  - data for the request issued last cycle
//   redirect_valid, redirect_pc- restart fetch at redirect_pc, dropping old work
//   inst_valid, inst, inst_pc  - FIFO head presented to decode
//   inst_ready                 - decode accepts the head this cycle
module fetch_stage
  import core_pkg::*;
#(
  parameter int IW    = core_pkg::IW,
  parameter int AW    = core_pkg::AW,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;
  logic          resp_pending;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          push;
  entry_t        wr_entry;
  entry_t        head;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  // A redirect flushes the buffer, so the response arriving now is stale.
  assign push       = resp_pending & ~redirect_valid;

  // Slots that will be committed after this cycle; a new request is only safe
  // if its response is guaranteed a free slot next cycle.
  assign occupancy = {1'b0, count} + (CW+1)'(resp_pending) - (CW+1)'(pop);
  assign imem_en   = ~rst & (redirect_valid | (occupancy < (CW+1)'(DEPTH)));
  assign imem_addr = rst ? '0 : (redirect_valid ? redirect_pc : fetch_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= '0;
      resp_pending <= 1'b0;
      resp_pc      <= '0;
    end else begin
      resp_pending <= imem_en;
      resp_pc      <= imem_addr;
      if (imem_en) begin
        fetch_pc <= imem_addr + AW'(1);
      end
    end
  end

  assign wr_entry.inst = imem_data;
  assign wr_entry.pc   = resp_pc;

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [4:0]  imem_addr;
  logic [13:0] imem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic        inst_valid;
  logic [13:0] inst;
  logic [4:0]  inst_pc;
  logic        inst_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address k is 0x100 + k.
  always @(posedge clk) begin
    if (imem_en) imem_data <= 14'h100 + 14'(imem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_en got %b exp 0", imem_en); end
    tests_run++;
    if (imem_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_addr got %0d exp 0", imem_addr); end
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    tests_run++;
    if (inst !== 14'd0) begin tests_failed++; $display("FAIL reset_inst got %h exp 0", inst); end
    tests_run++;
    if (inst_pc !== 5'd0) begin tests_failed++; $display("FAIL reset_pc got %0d exp 0", inst_pc); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests_run++;
      if (imem_en !== 1'b1) begin tests_failed++; $display("FAIL stream_en c=%0d got %b exp 1", c, imem_en); end
      tests_run++;
      if (imem_addr !== 5'(c)) begin tests_failed++; $display("FAIL stream_addr c=%0d got %0d exp %0d", c, imem_addr, c); end
      tests_run++;
      if (inst_valid !== (c >= 2)) begin tests_failed++; $display("FAIL stream_valid c=%0d got %b exp %b", c, inst_valid, c >= 2); end
      if (c >= 2) begin
        tests_run++;
        if (inst_pc !== 5'(c - 2) || inst !== 14'(256 + c - 2)) begin
          tests_failed++;
          $display("FAIL stream_data c=%0d got pc %0d inst %h exp pc %0d inst %h", c, inst_pc, inst, c - 2, 14'(256 + c - 2));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bit exp_en;
      int exp_addr;
      int exp_pc;
      inst_ready = (c < 2 || c >= 7);
      exp_en   = (c < 2 || c >= 7);
      exp_addr = (c < 2) ? c : c - 5;
      exp_pc   = (c <= 7) ? 0 : c - 7;
      @(negedge clk);
      tests_run++;
      if (imem_en !== exp_en) begin tests_failed++; $display("FAIL bp_en c=%0d got %b exp %b", c, imem_en, exp_en); end
      if (exp_en) begin
        tests_run++;
        if (imem_addr !== 5'(exp_addr)) begin tests_failed++; $display("FAIL bp_addr c=%0d got %0d exp %0d", c, imem_addr, exp_addr); end
      end
      tests_run++;
      if (inst_valid !== (c >= 2)) begin tests_failed++; $display("FAIL bp_valid c=%0d got %b exp %b", c, inst_valid, c >= 2); end
      if (c >= 2) begin
        tests_run++;
        if (inst_pc !== 5'(exp_pc) || inst !== 14'(256 + exp_pc)) begin
          tests_failed++;
          $display("FAIL bp_data c=%0d got pc %0d inst %h exp pc %0d", c, inst_pc, inst, exp_pc);
        end
      end
      @(posedge clk);
      #1;
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    inst_ready = 1'b1;
    redirect_pc = 5'd20;
    for (int c = 0; c < 10; c++) begin
      int  exp_addr;
      bit  exp_valid;
      int  exp_pc;
      redirect_valid = (c == 5);
      if (c < 5) begin
        exp_addr = c; exp_valid = (c >= 2); exp_pc = c - 2;
      end else if (c == 5) begin
        exp_addr = 20; exp_valid = 1'b1; exp_pc = 3;
      end else if (c == 6) begin
        exp_addr = 21; exp_valid = 1'b0; exp_pc = 0;
      end else begin
        exp_addr = c + 15; exp_valid = 1'b1; exp_pc = c + 13;
      end
      @(negedge clk);
      tests_run++;
      if (imem_en !== 1'b1 || imem_addr !== 5'(exp_addr)) begin
        tests_failed++;
        $display("FAIL redir_req c=%0d got en %b addr %0d exp en 1 addr %0d", c, imem_en, imem_addr, exp_addr);
      end
      tests_run++;
      if (inst_valid !== exp_valid) begin tests_failed++; $display("FAIL redir_valid c=%0d got %b exp %b", c, inst_valid, exp_valid); end
      if (exp_valid) begin
        tests_run++;
        if (inst_pc !== 5'(exp_pc) || inst !== 14'(256 + exp_pc)) begin
          tests_failed++;
          $display("FAIL redir_data c=%0d got pc %0d inst %h exp pc %0d", c, inst_pc, inst, exp_pc);
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    inst_ready = 1'b1;
    redirect_pc = 5'd30;
    for (int c = 0; c < 6; c++) begin
      logic [4:0] exp_addr;
      logic [4:0] exp_pc;
      redirect_valid = (c == 0);
      exp_addr = 5'(30 + c);
      exp_pc   = 5'(28 + c);
      @(negedge clk);
      tests_run++;
      if (imem_addr !== exp_addr) begin tests_failed++; $display("FAIL wrap_addr c=%0d got %0d exp %0d", c, imem_addr, exp_addr); end
      tests_run++;
      if (inst_valid !== (c >= 2)) begin tests_failed++; $display("FAIL wrap_valid c=%0d got %b exp %b", c, inst_valid, c >= 2); end
      if (c >= 2) begin
        tests_run++;
        if (inst_pc !== exp_pc || inst !== 14'h100 + 14'(exp_pc)) begin
          tests_failed++;
          $display("FAIL wrap_data c=%0d got pc %0d inst %h exp pc %0d", c, inst_pc, inst, exp_pc);
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_full();
    int exp_en    [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 1};
    int exp_addr  [9] = '{0, 1, 0, 5, 6, 0, 7, 8, 9};
    int exp_valid [9] = '{0, 0, 1, 1, 0, 1, 1, 1, 1};
    int exp_pc    [9] = '{0, 0, 0, 0, 0, 5, 5, 6, 7};
    do_reset();
    redirect_pc = 5'd5;
    for (int c = 0; c < 9; c++) begin
      redirect_valid = (c == 3);
      inst_ready = (c >= 6);
      @(negedge clk);
      tests_run++;
      if (imem_en !== 1'(exp_en[c])) begin tests_failed++; $display("FAIL full_en c=%0d got %b exp %0d", c, imem_en, exp_en[c]); end
      if (exp_en[c] != 0) begin
        tests_run++;
        if (imem_addr !== 5'(exp_addr[c])) begin tests_failed++; $display("FAIL full_addr c=%0d got %0d exp %0d", c, imem_addr, exp_addr[c]); end
      end
      tests_run++;
      if (inst_valid !== 1'(exp_valid[c])) begin tests_failed++; $display("FAIL full_valid c=%0d got %b exp %0d", c, inst_valid, exp_valid[c]); end
      if (exp_valid[c] != 0) begin
        tests_run++;
        if (inst_pc !== 5'(exp_pc[c]) || inst !== 14'(256 + exp_pc[c])) begin
          tests_failed++;
          $display("FAIL full_data c=%0d got pc %0d inst %h exp pc %0d", c, inst_pc, inst, exp_pc[c]);
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    redirect_pc = 5'd9;
    for (int c = 0; c < 5; c++) begin
      redirect_valid = (c == 2);
      @(negedge clk);
      if (c == 2) begin
        tests_run++;
        if (imem_en !== 1'b1 || imem_addr !== 5'd9) begin tests_failed++; $display("FAIL infl_req got en %b addr %0d exp en 1 addr 9", imem_en, imem_addr); end
      end
      if (c == 3) begin
        tests_run++;
        if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL infl_drop got valid %b exp 0", inst_valid); end
      end
      if (c == 4) begin
        tests_run++;
        if (inst_valid !== 1'b1 || inst_pc !== 5'd9 || inst !== 14'h109) begin
          tests_failed++;
          $display("FAIL infl_data got valid %b pc %0d inst %h exp 1 9 109", inst_valid, inst_pc, inst);
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_en !== 1'b0 || imem_addr !== 5'd0) begin tests_failed++; $display("FAIL mid_rst_comb got en %b addr %0d exp 0 0", imem_en, imem_addr); end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL mid_rst_state got valid %b en %b addr %0d exp 0 0 0", inst_valid, imem_en, imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (imem_en !== 1'b1 || imem_addr !== 5'(c)) begin tests_failed++; $display("FAIL mid_restart_addr c=%0d got %0d exp %0d", c, imem_addr, c); end
      tests_run++;
      if (inst_valid !== (c >= 2)) begin tests_failed++; $display("FAIL mid_restart_valid c=%0d got %b exp %b", c, inst_valid, c >= 2); end
      if (c >= 2) begin
        tests_run++;
        if (inst_pc !== 5'(c - 2) || inst !== 14'(256 + c - 2)) begin
          tests_failed++;
          $display("FAIL mid_restart_data c=%0d got pc %0d exp %0d", c, inst_pc, c - 2);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_full();
    test_redirect_inflight();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
